// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types, constants and key decode helpers for the keypad loader
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    LOAD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int MAX_DIGITS = 3;
  localparam int KEY_W      = 10;
  localparam int DIGIT_W    = 2;

  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

  function automatic logic [3:0] onehot_index(input logic [KEY_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_loader_if.sv
// rtl/keypad_loader_if.sv - raw keypad inputs and timer load interface signals
interface keypad_loader_if;
  import microwave_pkg::*;

  logic [KEY_W-1:0]   keypad;
  logic               clear_key;
  logic [3:0]         data;
  logic               loadn;
  logic [DIGIT_W-1:0] digit_count;
  logic               full;

  modport master (
    output keypad,
    output clear_key,
    input  data,
    input  loadn,
    input  digit_count,
    input  full
  );

  modport slave (
    input  keypad,
    input  clear_key,
    output data,
    output loadn,
    output digit_count,
    output full
  );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (clear) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_loader.sv
// rtl/keypad_loader.sv - debounced keypad to BCD digit loader with three-digit saturation
module keypad_loader
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic             clk,
  input logic             clear,
  keypad_loader_if.slave  bus
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [KEY_W:0]     sync_q;
  logic [KEY_W-1:0]   keys_s;
  logic               clr_s;

  state_t             state, state_n;
  logic [7:0]         cnt, cnt_n, cnt_inc;
  logic [3:0]         idx, idx_n;
  logic [3:0]         data_q, data_n;
  logic [DIGIT_W-1:0] count, count_n;
  logic               full;
  logic               strobe;

  sync_2ff #(.WIDTH(KEY_W + 1)) u_sync (
    .clk   (clk),
    .clear (clear),
    .d     ({bus.clear_key, bus.keypad}),
    .q     (sync_q)
  );

  assign keys_s  = sync_q[KEY_W-1:0];
  assign clr_s   = sync_q[KEY_W];
  assign cnt_inc = cnt + 8'd1;
  assign full    = (count == DIGIT_W'(MAX_DIGITS));

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      data_q <= '0;
      count  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      data_q <= data_n;
      count  <= count_n;
    end
  end

  // cnt is shared: stable-press samples in DEBOUNCE, all-released samples in WAIT_RELEASE
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data_q;
    count_n = count;
    strobe  = 1'b0;
    if (clr_s) begin
      state_n = WAIT_RELEASE;
      cnt_n   = '0;
      count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_onehot(keys_s)) begin
            idx_n   = onehot_index(keys_s);
            cnt_n   = '0;
            state_n = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (keys_s == (KEY_W'(1) << idx)) begin
            if (cnt_inc >= DB_LIMIT) begin
              cnt_n   = '0;
              state_n = LOAD;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        LOAD: begin
          if (!full) begin
            strobe  = 1'b1;
            data_n  = idx;
            count_n = count + DIGIT_W'(1);
          end
          cnt_n   = '0;
          state_n = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (keys_s != '0) begin
            cnt_n = '0;
          end else if (cnt_inc >= DB_LIMIT) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // data shows the new digit during its strobe cycle, then holds it from data_q
  assign bus.data        = strobe ? idx : data_q;
  assign bus.loadn       = ~strobe;
  assign bus.digit_count = count;
  assign bus.full        = full;

endmodule

// File: tb/tb_keypad_loader.sv
// tb/tb_keypad_loader.sv - self-checking bench: directed scenarios plus randomized press sequences
module tb_keypad_loader;
  import microwave_pkg::*;

  localparam int D = 4;
  localparam int QMAX = 4096;

  logic clk = 1'b0;
  logic clear = 1'b1;

  keypad_loader_if bus();

  keypad_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         acc_at [QMAX];
  bit         clr_at [QMAX];
  logic [9:0] kp_q [$];
  logic       ck_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.keypad    = '0;
    bus.clear_key = 1'b0;
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
  endtask

  // Index 0 is the cycle following the first edge that samples the key.
  task automatic run_key(input logic [9:0] mask, input int hold, input int gap,
                         output int pulses, output int first_idx, output logic [3:0] first_data);
    pulses = 0;
    first_idx = -1;
    first_data = '0;
    for (int i = 0; i < hold + gap; i++) begin
      bus.keypad = (i < hold) ? mask : 10'd0;
      tick();
      if (bus.loadn == 1'b0) begin
        if (pulses == 0) begin
          first_idx  = i;
          first_data = bus.data;
        end
        pulses++;
      end
    end
  endtask

  initial begin
    int pulses, pidx, r, k, k2, hold, gap, len, s, mc;
    logic [3:0] pdata, md;
    int keys [4];
    bit exp_strobe;

    keys = '{1, 2, 9, 4};
    bus.keypad = '0;
    bus.clear_key = 1'b0;

    // reset state
    do_reset();
    check("rst_loadn", 32'(bus.loadn), 32'd1);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_count", 32'(bus.digit_count), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);

    // key 5 held 20 cycles
    run_key(10'b0000100000, 20, 12, pulses, pidx, pdata);
    check("k5_pulses", 32'(pulses), 32'd1);
    check("k5_idx", 32'(pidx), 32'(D + 2));
    check("k5_data", 32'(pdata), 32'd5);
    check("k5_count", 32'(bus.digit_count), 32'd1);

    // bounce on key 3
    do_reset();
    run_key(10'b0000001000, 2, 12, pulses, pidx, pdata);
    check("bounce_pulses", 32'(pulses), 32'd0);
    check("bounce_count", 32'(bus.digit_count), 32'd0);

    // four digits, saturation at three
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_key(10'(1 << keys[i]), 10, 12, pulses, pidx, pdata);
      check("sat_pulses", 32'(pulses), (i < 3) ? 32'd1 : 32'd0);
      if (i < 3) check("sat_data", 32'(pdata), 32'(keys[i]));
    end
    check("sat_count", 32'(bus.digit_count), 32'd3);
    check("sat_full", 32'(bus.full), 32'd1);
    check("sat_hold_data", 32'(bus.data), 32'd9);

    // two keys at once, then a clean single key from IDLE
    do_reset();
    run_key(10'b0010000100, 20, 12, pulses, pidx, pdata);
    check("multi_pulses", 32'(pulses), 32'd0);
    check("multi_count", 32'(bus.digit_count), 32'd0);
    run_key(10'b0001000000, 10, 12, pulses, pidx, pdata);
    check("after_multi_idx", 32'(pidx), 32'(D + 2));
    check("after_multi_data", 32'(pdata), 32'd6);

    // clear mid-debounce with key 8 still held afterwards
    do_reset();
    pulses = 0;
    bus.keypad = 10'b0100000000;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.loadn == 1'b0) pulses++;
    end
    clear = 1'b1;
    tick();
    if (bus.loadn == 1'b0) pulses++;
    check("clr_db_pre", 32'(pulses), 32'd0);
    clear = 1'b0;
    run_key(10'b0100000000, 20, 12, pulses, pidx, pdata);
    check("clr_db_pulses", 32'(pulses), 32'd1);
    check("clr_db_idx", 32'(pidx), 32'(D + 2));
    check("clr_db_data", 32'(pdata), 32'd8);

    // clear during the LOAD cycle
    do_reset();
    bus.keypad = 10'b0000010000;
    for (int i = 0; i < D + 3; i++) tick();
    check("clr_ld_strobe", 32'(bus.loadn), 32'd0);
    clear = 1'b1;
    tick();
    check("clr_ld_loadn", 32'(bus.loadn), 32'd1);
    check("clr_ld_count", 32'(bus.digit_count), 32'd0);
    check("clr_ld_data", 32'(bus.data), 32'd0);
    clear = 1'b0;
    bus.keypad = '0;
    for (int i = 0; i < 12; i++) tick();

    // clear_key with two digits loaded
    do_reset();
    run_key(10'b0000001000, 10, 12, pulses, pidx, pdata);
    run_key(10'b0010000000, 10, 12, pulses, pidx, pdata);
    check("ck_count2", 32'(bus.digit_count), 32'd2);
    bus.clear_key = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.clear_key = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("ck_count", 32'(bus.digit_count), 32'd0);
    check("ck_full", 32'(bus.full), 32'd0);
    check("ck_data", 32'(bus.data), 32'd7);
    run_key(10'b0000000001, 10, 12, pulses, pidx, pdata);
    check("ck_next_pulses", 32'(pulses), 32'd1);
    check("ck_next_data", 32'(pdata), 32'd0);
    check("ck_next_count", 32'(bus.digit_count), 32'd1);

    // randomized sequence against an event-level model
    for (int i = 0; i < QMAX; i++) begin
      acc_at[i] = -1;
      clr_at[i] = 1'b0;
    end
    for (int e = 0; e < 60; e++) begin
      r   = $urandom_range(0, 9);
      gap = $urandom_range(D + 6, D + 12);
      s   = kp_q.size();
      if (r < 5) begin
        k    = $urandom_range(0, 9);
        hold = $urandom_range(D + 1, D + 8);
        acc_at[s + D + 2] = k;
        for (int i = 0; i < hold; i++) begin kp_q.push_back(10'(1 << k)); ck_q.push_back(1'b0); end
      end else if (r < 7) begin
        k    = $urandom_range(0, 9);
        hold = $urandom_range(1, D);
        for (int i = 0; i < hold; i++) begin kp_q.push_back(10'(1 << k)); ck_q.push_back(1'b0); end
      end else if (r < 9) begin
        k  = $urandom_range(0, 9);
        k2 = (k + $urandom_range(1, 9)) % 10;
        hold = $urandom_range(1, 12);
        for (int i = 0; i < hold; i++) begin kp_q.push_back(10'((1 << k) | (1 << k2))); ck_q.push_back(1'b0); end
      end else begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
          clr_at[s + 2 + i] = 1'b1;
          kp_q.push_back(10'd0);
          ck_q.push_back(1'b1);
        end
      end
      for (int i = 0; i < gap; i++) begin kp_q.push_back(10'd0); ck_q.push_back(1'b0); end
    end

    do_reset();
    mc = 0;
    md = '0;
    for (int j = 0; j < kp_q.size(); j++) begin
      bus.keypad    = kp_q[j];
      bus.clear_key = ck_q[j];
      tick();
      if (clr_at[j]) mc = 0;
      exp_strobe = (acc_at[j] >= 0) && (mc < MAX_DIGITS);
      if (exp_strobe) md = 4'(acc_at[j]);
      check("rnd_loadn", 32'(bus.loadn), exp_strobe ? 32'd0 : 32'd1);
      check("rnd_data", 32'(bus.data), 32'(md));
      check("rnd_count", 32'(bus.digit_count), 32'(mc));
      check("rnd_full", 32'(bus.full), (mc == MAX_DIGITS) ? 32'd1 : 32'd0);
      if (exp_strobe) mc++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_loader.md
KEYPAD_LOADER -- requirements
Module: keypad_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: the number of consecutive stable synchronized samples required to accept a press or a release (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port keypad  input  10  raw key lines, asynchronous to clk; bit i high means digit key i is pressed.
REQ-005 SHALL have port clear_key  input  1  raw user "clear entry" key, asynchronous to clk, active-high.
REQ-006 SHALL have port data  output  4  BCD digit presented to the timer load interface.
REQ-007 SHALL have port loadn  output  1  active-low load strobe, low for exactly one cycle per accepted digit.
REQ-008 SHALL have port digit_count  output  2  number of digits loaded since the last reset or clear_key, range 0..3.
REQ-009 SHALL have port full  output  1  high when digit_count == 3.

Function
REQ-010 SHALL pass keypad and clear_key through a two-flop synchronizer; all logic below uses only the synchronized values.
REQ-011 SHALL implement the FSM states IDLE, DEBOUNCE, LOAD and WAIT_RELEASE.
REQ-012 In IDLE, when exactly one synchronized key bit is high, SHALL capture its index and go to DEBOUNCE with the stability count set to 0; zero keys or two or more keys SHALL leave the FSM in IDLE.
REQ-013 In DEBOUNCE, while the synchronized keypad equals the captured one-hot pattern, SHALL increment the stability count; reaching DEBOUNCE_CYCLES SHALL go to LOAD.
REQ-014 In DEBOUNCE, any mismatch SHALL return the FSM to IDLE with no strobe.
REQ-015 In LOAD, if full is low: loadn is 0 for that one cycle, data equals the captured index in BCD, and digit_count increments at the end of the cycle; if full is high: loadn stays 1 and the count is unchanged; next state is WAIT_RELEASE.
REQ-016 In WAIT_RELEASE, SHALL return to IDLE only after DEBOUNCE_CYCLES consecutive cycles with all synchronized keys low; any key high restarts that count.
REQ-017 Latency: for a key first sampled high at edge 1 and held, loadn SHALL be low during the cycle following edge DEBOUNCE_CYCLES+3 (edge 7 at the default).
REQ-018 data SHALL hold the last loaded digit between strobes.
REQ-019 loadn SHALL be 1 in every state other than LOAD.
REQ-020 Synchronized clear_key high SHALL take priority over all key activity: the FSM goes to WAIT_RELEASE, digit_count becomes 0, and loadn stays 1 that cycle; data is unchanged.
REQ-021 digit_count SHALL saturate at 3 and never wrap.
REQ-022 full SHALL be combinational from digit_count.

Reset
REQ-023 When clear is high at a rising edge, the block SHALL set: FSM to IDLE, both synchronizers to 0, stability count to 0, data to 0, loadn to 1, digit_count to 0 and full to 0.
REQ-024 clear asserted mid-DEBOUNCE or during LOAD SHALL abort without issuing a strobe in the following cycle; a key still held after reset SHALL be re-debounced from IDLE.

Structure
REQ-025 SHALL declare the FSM state type and the constant MAX_DIGITS = 3 in the shared package microwave_pkg.
REQ-026 SHALL implement the synchronizer as sub-module sync_2ff, parameterized by width and instantiated once with width 11.

Verification
REQ-027 The bench SHALL cover: keypad = 10'b0000100000 held 20 cycles -> one loadn low pulse at cycle 7 with data = 5, digit_count = 1.
REQ-028 The bench SHALL cover: key 3 pulsed for 2 cycles (bounce), then released -> no loadn pulse, digit_count = 0.
REQ-029 The bench SHALL cover: key 1, then 2, 9 and 4 each pressed and released -> exactly three strobes with data 1, 2, 9; the fourth press produces no strobe; full = 1.
REQ-030 The bench SHALL cover: keys 2 and 7 pressed together for 20 cycles -> no strobe; FSM stays IDLE.
REQ-031 The bench SHALL cover: key 8 held with clear asserted at cycle 5 and key still held after clear -> no strobe before clear, then a single strobe with data = 8 seven cycles after clear deasserts.
REQ-032 The bench SHALL cover: with digit_count = 2, clear_key pressed -> digit_count = 0 and full = 0, and the next key press is accepted normally.
